hamming_serial_dec: RTL and testbench

- Parametrised serial Hamming SEC decoder, successor to the fixed 15/11 serial decoder path.
- Accepts a bit-serial codeword with valid/ready, corrects any single-bit error and emits the K data bits bit-serially with valid/ready backpressure.
- Double-buffered: the next frame can shift in while the previous one drains.
- Reports per-frame error flags and the syndrome, and keeps a saturating corrected-error count for link monitoring.

---
 rtl/hamming_pkg.sv | 37 +++
 rtl/hamming_syndrome_correct.sv | 42 ++++
 rtl/hamming_serial_dec.sv | 165 ++++++++++++++++
 tb/tb_hamming_serial_dec.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the parametrised serial Hamming decoder: codeword geometry,
// data-position mapping and the output-side state encoding.
package hamming_pkg;

  function automatic int N_OF(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int K_OF(input int r);
    return N_OF(r) - r;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit i lives at the i-th non-power-of-two position, counting from 1.
  function automatic int data_pos(input int i, input int r);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= 63; p++) begin
      if (p <= N_OF(r) && !is_pow2(p)) begin
        if (cnt == i) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_SHIFT = 1'b1
  } out_state_e;

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational Hamming syndrome computation, single-bit correction and data
// extraction; frame bit 0 holds codeword position 1.
module hamming_syndrome_correct
  import hamming_pkg::*;
#(
  parameter int R = 4,
  localparam int N = N_OF(R),
  localparam int K = K_OF(R)
) (
  input  logic [N-1:0] frame,
  input  logic         correct_en,
  output logic [K-1:0] data,
  output logic [R-1:0] syndrome
);

  // Positions whose index has bit j set; bit p-1 of the mask is position p.
  function automatic logic [N-1:0] cover_mask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int p = N; p >= 1; p--)
      m = {m[N-2:0], ((p >> j) & 1) == 1};
    return m;
  endfunction

  logic [N-1:0] flip;
  logic [N-1:0] fixed;

  for (genvar j = 0; j < R; j++) begin : g_syn
    localparam logic [N-1:0] MASK = cover_mask(j);
    assign syndrome[j] = ^(frame & MASK);
  end

  // A non-zero syndrome is always a legal position because N = 2^R-1.
  assign flip  = (correct_en && syndrome != '0) ? (N'(1) << (syndrome - R'(1))) : '0;
  assign fixed = frame ^ flip;

  for (genvar g = 0; g < K; g++) begin : g_ext
    localparam int P = data_pos(g, R);
    assign data[g] = fixed[P-1];
  end

endmodule

// File: rtl/hamming_serial_dec.sv
// Double-buffered bit-serial Hamming SEC decoder with valid/ready on both sides.
// Define HAMMING_SECDED_EN for SECDED framing (N+1 bits, overall parity, err_double).
module hamming_serial_dec
  import hamming_pkg::*;
#(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             flush,
  input  logic             sl_in,
  input  logic             sl_in_valid,
  output logic             sl_in_ready,
  output logic             sl_out,
  output logic             sl_out_valid,
  input  logic             sl_out_ready,
  output logic             err_single,
  output logic [R-1:0]     syndrome,
`ifdef HAMMING_SECDED_EN
  output logic             err_double,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int N  = N_OF(R);
  localparam int K  = K_OF(R);
`ifdef HAMMING_SECDED_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif
  localparam int CW = $clog2(FL);
  localparam int KW = $clog2(K);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CW-1:0] in_cnt;
  logic [FL-1:0] in_sr;
  logic          in_full;
  logic          in_acc;
  logic          in_last;
  logic          frame_avail;
  logic [FL-1:0] cur_frame;

  out_state_e    state_q;
  out_state_e    state_d;
  logic [K-1:0]  out_sr;
  logic [KW-1:0] out_cnt;
  logic          out_acc;
  logic          out_last;
  logic          load_ok;
  logic          load;

  logic [K-1:0]  dec_data;
  logic [R-1:0]  dec_syn;
  logic          correct_en;
  logic          is_single;
`ifdef HAMMING_SECDED_EN
  logic          par_odd;
  logic          is_double;
`endif

  // Input stage: serial bits shift in from the top so position 1 ends at bit 0.
  assign sl_in_ready = ~in_full;
  assign in_acc      = sl_in_valid & ~in_full;
  assign in_last     = in_acc & (in_cnt == CW'(FL - 1));
  assign cur_frame   = in_full ? in_sr : {sl_in, in_sr[FL-1:1]};
  assign frame_avail = ~flush & (in_full | in_last);

  assign out_acc  = (state_q == OUT_SHIFT) & sl_out_ready;
  assign out_last = out_acc & (out_cnt == KW'(K - 1));
  assign load_ok  = (state_q == OUT_IDLE) | out_last;
  assign load     = frame_avail & load_ok;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      in_cnt  <= '0;
      in_sr   <= '0;
      in_full <= 1'b0;
    end else if (flush) begin
      in_cnt  <= '0;
      in_full <= 1'b0;
    end else begin
      if (in_acc) begin
        in_sr  <= {sl_in, in_sr[FL-1:1]};
        in_cnt <= in_last ? '0 : in_cnt + CW'(1);
      end
      if (load)         in_full <= 1'b0;
      else if (in_last) in_full <= 1'b1;
    end
  end

  // Decode stage: combinational correction on the frame being transferred.
  hamming_syndrome_correct #(.R(R)) u_dec (
    .frame      (cur_frame[N-1:0]),
    .correct_en (correct_en),
    .data       (dec_data),
    .syndrome   (dec_syn)
  );

`ifdef HAMMING_SECDED_EN
  // Even overall parity means an even number of flips: correcting would make it worse.
  assign par_odd    = ^cur_frame;
  assign correct_en = par_odd;
  assign is_single  = par_odd;
  assign is_double  = ~par_odd & (dec_syn != '0);
`else
  assign correct_en = 1'b1;
  assign is_single  = |dec_syn;
`endif

  // Output stage: two-process FSM draining the output register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= OUT_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    sl_out_valid = 1'b0;
    sl_out       = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (load) state_d = OUT_SHIFT;
      end
      OUT_SHIFT: begin
        sl_out_valid = 1'b1;
        sl_out       = out_sr[0];
        if (out_last && !load) state_d = OUT_IDLE;
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      out_sr     <= '0;
      out_cnt    <= '0;
      err_single <= 1'b0;
      syndrome   <= '0;
      err_count  <= '0;
`ifdef HAMMING_SECDED_EN
      err_double <= 1'b0;
`endif
    end else begin
      err_single <= load & is_single;
`ifdef HAMMING_SECDED_EN
      err_double <= load & is_double;
`endif
      if (load) begin
        out_sr   <= dec_data;
        out_cnt  <= '0;
        syndrome <= dec_syn;
        if (is_single) err_count <= sat_inc(err_count);
      end else if (out_acc) begin
        out_sr  <= out_sr >> 1;
        out_cnt <= out_cnt + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_serial_dec.sv
// Directed bench for hamming_serial_dec (R=4, narrow error counter to reach saturation).
module tb_hamming_serial_dec;
  localparam int R     = 4;
  localparam int CNT_W = 3;
  localparam int N     = 15;
  localparam int K     = 11;

  logic             clk = 1'b0;
  logic             RST;
  logic             flush;
  logic             sl_in;
  logic             sl_in_valid;
  logic             sl_in_ready;
  logic             sl_out;
  logic             sl_out_valid;
  logic             sl_out_ready;
  logic             err_single;
  logic [R-1:0]     syndrome;
  logic [CNT_W-1:0] err_count;
`ifdef HAMMING_SECDED_EN
  logic             err_double;
  int               ed_cnt = 0;
`endif

  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  int   es_cnt = 0;
  logic out_q[$];
  int   out_cyc_q[$];
  int   in_cyc_q[$];
  logic prev_stall = 1'b0;
  logic prev_bit = 1'b0;

  hamming_serial_dec #(.R(R), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .RST          (RST),
    .flush        (flush),
    .sl_in        (sl_in),
    .sl_in_valid  (sl_in_valid),
    .sl_in_ready  (sl_in_ready),
    .sl_out       (sl_out),
    .sl_out_valid (sl_out_valid),
    .sl_out_ready (sl_out_ready),
    .err_single   (err_single),
    .syndrome     (syndrome),
`ifdef HAMMING_SECDED_EN
    .err_double   (err_double),
`endif
    .err_count    (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample mid-low-phase, after the bench has driven its inputs for the coming edge.
  always begin
    @(negedge clk);
    #3;
    if (sl_in_valid && sl_in_ready && !flush) in_cyc_q.push_back(cyc);
    if (sl_out_valid && sl_out_ready) begin
      out_q.push_back(sl_out);
      out_cyc_q.push_back(cyc);
    end
    if (err_single) es_cnt++;
`ifdef HAMMING_SECDED_EN
    if (err_double) ed_cnt++;
`endif
    if (prev_stall && RST) begin
      vec++;
      if (sl_out_valid !== 1'b1 || sl_out !== prev_bit) begin
        miss++;
        $display("FAIL stall_hold: valid=%b bit=%b, required valid=1 bit=%b", sl_out_valid, sl_out, prev_bit);
      end
    end
    prev_stall = RST && sl_out_valid && !sl_out_ready;
    prev_bit   = sl_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    out_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  function automatic logic [31:0] pack_out();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < out_q.size() && i < 32; i++) v = v | (32'(out_q[i]) << i);
    return v;
  endfunction

  function automatic bit contiguous();
    bit ok;
    ok = 1'b1;
    for (int i = 1; i < out_cyc_q.size(); i++)
      if (out_cyc_q[i] != out_cyc_q[i-1] + 1) ok = 1'b0;
    return ok;
  endfunction

  task automatic push_bit(input logic b);
    int g;
    g = 0;
    sl_in       = b;
    sl_in_valid = 1'b1;
    while (sl_in_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (sl_in_ready !== 1'b1) begin
      vec++;
      miss++;
      $display("FAIL push_timeout: sl_in_ready=%b, required 1", sl_in_ready);
    end
    @(negedge clk);
    sl_in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] good, input int f1, input int f2);
    logic [N-1:0] cw;
`ifdef HAMMING_SECDED_EN
    logic par;
    par = ^good;
`endif
    cw = good;
    if (f1 > 0) cw = cw ^ (N'(1) << (f1 - 1));
    if (f2 > 0) cw = cw ^ (N'(1) << (f2 - 1));
    for (int p = 0; p < N; p++) begin
      push_bit(cw[0]);
      cw = cw >> 1;
    end
`ifdef HAMMING_SECDED_EN
    push_bit(par);
`endif
  endtask

  task automatic wait_out(input int n);
    int g;
    g = 0;
    while (out_q.size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    if (out_q.size() < n) begin
      vec++;
      miss++;
      $display("FAIL out_timeout: got %0d bits, required %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; flush = 1'b0; sl_in = 1'b0; sl_in_valid = 1'b0; sl_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    vec++; if (sl_in_ready !== 1'b1) begin miss++; $display("FAIL rst_in_ready: got %b, required 1", sl_in_ready); end
    vec++; if (sl_out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid: got %b, required 0", sl_out_valid); end
    vec++; if (sl_out !== 1'b0) begin miss++; $display("FAIL rst_out: got %b, required 0", sl_out); end
    vec++; if (err_single !== 1'b0) begin miss++; $display("FAIL rst_err_single: got %b, required 0", err_single); end
    vec++; if (syndrome !== 4'h0) begin miss++; $display("FAIL rst_syndrome: got %h, required 0", syndrome); end
    vec++; if (err_count !== 3'd0) begin miss++; $display("FAIL rst_err_count: got %0d, required 0", err_count); end
  endtask

  task automatic test_all_zero();
    int es0;
    int first;
    int last_in;
    clear_logs();
    es0 = es_cnt;
    sl_out_ready = 1'b1;
    send_frame('0, 0, 0);
    wait_out(K);
    first   = (out_cyc_q.size() > 0) ? out_cyc_q[0] : -1;
    last_in = (in_cyc_q.size() > 0) ? in_cyc_q[in_cyc_q.size()-1] : -100;
    vec++; if (out_q.size() != K) begin miss++; $display("FAIL zero_len: got %0d, required %0d", out_q.size(), K); end
    vec++; if (pack_out() !== 32'h0) begin miss++; $display("FAIL zero_data: got %h, required 0", pack_out()); end
    vec++; if (first != last_in + 1) begin miss++; $display("FAIL zero_latency: first out cycle %0d, required %0d", first, last_in + 1); end
    vec++; if (!contiguous()) begin miss++; $display("FAIL zero_contig: got gaps, required none"); end
    vec++; if (es_cnt - es0 != 0) begin miss++; $display("FAIL zero_err_single: got %0d pulses, required 0", es_cnt - es0); end
    vec++; if (syndrome !== 4'h0) begin miss++; $display("FAIL zero_syndrome: got %h, required 0", syndrome); end
  endtask

  task automatic test_all_ones();
    logic [CNT_W-1:0] ec0;
    clear_logs();
    ec0 = err_count;
    send_frame(15'h7FFF, 0, 0);
    wait_out(K);
    vec++; if (pack_out() !== 32'h7FF || out_q.size() != K) begin miss++; $display("FAIL ones_data: got %h (%0d bits), required 7ff (11 bits)", pack_out(), out_q.size()); end
    vec++; if (syndrome !== 4'h0) begin miss++; $display("FAIL ones_syndrome: got %h, required 0", syndrome); end
    vec++; if (err_count !== ec0) begin miss++; $display("FAIL ones_err_count: got %0d, required %0d", err_count, ec0); end
  endtask

  task automatic test_single_err();
    int es0;
    clear_logs();
    es0 = es_cnt;
    send_frame('0, 5, 0);
    wait_out(K);
    vec++; if (syndrome !== 4'b0101) begin miss++; $display("FAIL se5_syndrome: got %b, required 0101", syndrome); end
    vec++; if (es_cnt - es0 != 1) begin miss++; $display("FAIL se5_pulse: got %0d pulse cycles, required 1", es_cnt - es0); end
    vec++; if (pack_out() !== 32'h0 || out_q.size() != K) begin miss++; $display("FAIL se5_data: got %h (%0d bits), required 0 (11 bits)", pack_out(), out_q.size()); end
    vec++; if (err_count !== 3'd1) begin miss++; $display("FAIL se5_err_count: got %0d, required 1", err_count); end
    // Data bit 0 (position 3) corrupted back to 0: correction must restore it first in order.
    clear_logs();
    send_frame(15'h0007, 3, 0);
    wait_out(K);
    vec++; if (pack_out() !== 32'h001) begin miss++; $display("FAIL se3_data: got %h, required 001", pack_out()); end
    vec++; if (syndrome !== 4'h3) begin miss++; $display("FAIL se3_syndrome: got %h, required 3", syndrome); end
    vec++; if (err_count !== 3'd2) begin miss++; $display("FAIL se3_err_count: got %0d, required 2", err_count); end
    // Last codeword position.
    clear_logs();
    send_frame(15'h7FFF, 15, 0);
    wait_out(K);
    vec++; if (pack_out() !== 32'h7FF) begin miss++; $display("FAIL se15_data: got %h, required 7ff", pack_out()); end
    vec++; if (syndrome !== 4'hF) begin miss++; $display("FAIL se15_syndrome: got %h, required f", syndrome); end
    vec++; if (err_count !== 3'd3) begin miss++; $display("FAIL se15_err_count: got %0d, required 3", err_count); end
  endtask

`ifdef HAMMING_SECDED_EN
  task automatic test_double_err();
    int es0;
    int ed0;
    clear_logs();
    es0 = es_cnt;
    ed0 = ed_cnt;
    send_frame('0, 3, 6);
    wait_out(K);
    vec++; if (ed_cnt - ed0 != 1) begin miss++; $display("FAIL de_pulse: got %0d, required 1", ed_cnt - ed0); end
    vec++; if (es_cnt - es0 != 0) begin miss++; $display("FAIL de_single: got %0d, required 0", es_cnt - es0); end
    vec++; if (err_count !== 3'd3) begin miss++; $display("FAIL de_err_count: got %0d, required 3", err_count); end
    vec++; if (pack_out() !== 32'h005) begin miss++; $display("FAIL de_data: got %h, required 005", pack_out()); end
  endtask
`endif

  task automatic test_back_to_back();
    clear_logs();
    sl_out_ready = 1'b0;
    send_frame(15'h0007, 0, 0);
    send_frame(15'h7FFF, 0, 0);
    vec++; if (sl_in_ready !== 1'b0) begin miss++; $display("FAIL b2b_in_ready_drop: got %b, required 0", sl_in_ready); end
    repeat (4) @(negedge clk);
    vec++; if (sl_out_valid !== 1'b1 || sl_out !== 1'b1) begin miss++; $display("FAIL b2b_hold: valid=%b bit=%b, required 1 1", sl_out_valid, sl_out); end
    sl_out_ready = 1'b1;
    wait_out(2 * K);
    vec++; if (out_q.size() != 2 * K) begin miss++; $display("FAIL b2b_len: got %0d, required 22", out_q.size()); end
    vec++; if (pack_out() !== 32'h3FF801) begin miss++; $display("FAIL b2b_data: got %h, required 3ff801", pack_out()); end
    vec++; if (!contiguous()) begin miss++; $display("FAIL b2b_bubble: got gaps, required none"); end
    vec++; if (sl_in_ready !== 1'b1) begin miss++; $display("FAIL b2b_in_ready_back: got %b, required 1", sl_in_ready); end
  endtask

  task automatic test_flush();
    clear_logs();
    sl_out_ready = 1'b0;
    send_frame(15'h0007, 0, 0);
    for (int i = 0; i < 7; i++) push_bit(1'b0);
    sl_in = 1'b0; sl_in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    sl_in_valid = 1'b0; flush = 1'b0;
    sl_out_ready = 1'b1;
    send_frame(15'h7FFF, 0, 0);
    wait_out(2 * K);
    vec++; if (pack_out() !== 32'h3FF801 || out_q.size() != 2 * K) begin miss++; $display("FAIL flush_data: got %h (%0d bits), required 3ff801 (22 bits)", pack_out(), out_q.size()); end
    vec++; if (syndrome !== 4'h0) begin miss++; $display("FAIL flush_syndrome: got %h, required 0", syndrome); end
  endtask

  task automatic test_saturate();
    int es0;
    es0 = es_cnt;
    sl_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame('0, 5, 0);
    vec++; if (err_count !== 3'd7) begin miss++; $display("FAIL sat_reach: got %0d, required 7", err_count); end
    send_frame('0, 5, 0);
    repeat (2) @(negedge clk);
    vec++; if (err_count !== 3'd7) begin miss++; $display("FAIL sat_hold: got %0d, required 7", err_count); end
    vec++; if (es_cnt - es0 != 5) begin miss++; $display("FAIL sat_pulses: got %0d, required 5", es_cnt - es0); end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sl_out_ready = 1'b0;
    send_frame(15'h0007, 0, 0);
    for (int i = 0; i < 5; i++) push_bit(1'b1);
    #2;
    RST = 1'b0;
    #1;
    vec++; if (sl_out_valid !== 1'b0) begin miss++; $display("FAIL rmid_out_valid: got %b, required 0", sl_out_valid); end
    vec++; if (sl_in_ready !== 1'b1) begin miss++; $display("FAIL rmid_in_ready: got %b, required 1", sl_in_ready); end
    vec++; if (err_count !== 3'd0) begin miss++; $display("FAIL rmid_err_count: got %0d, required 0", err_count); end
    @(negedge clk);
    RST = 1'b1;
    clear_logs();
    sl_out_ready = 1'b1;
    send_frame(15'h7FFF, 0, 0);
    wait_out(K);
    vec++; if (pack_out() !== 32'h7FF || out_q.size() != K) begin miss++; $display("FAIL rmid_data: got %h (%0d bits), required 7ff (11 bits)", pack_out(), out_q.size()); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_single_err();
`ifdef HAMMING_SECDED_EN
    test_double_err();
`endif
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
